// File: rtl/imsic_pkg.sv
// Shared definitions for the IMSIC MSI transmitter: msi_info field geometry,
// FSM state encoding and interrupt-file index constants.
package imsic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } msi_state_e;

  localparam int unsigned M_FILE = 0;
  localparam int unsigned S_FILE = 1;

  function automatic int unsigned hart_width(input int unsigned nr_harts);
    return (nr_harts > 1) ? $clog2(nr_harts) : 1;
  endfunction

  function automatic int unsigned file_width(input int unsigned nr_files);
    return $clog2(nr_files);
  endfunction

  function automatic int unsigned src_width(input int unsigned nr_src);
    return $clog2(nr_src);
  endfunction

  function automatic int unsigned msi_info_width(input int unsigned nr_harts,
                                                 input int unsigned nr_files,
                                                 input int unsigned nr_src);
    return hart_width(nr_harts) + file_width(nr_files) + src_width(nr_src);
  endfunction

  // msi_info is {hart, file, setipnum}, MSB..LSB
  function automatic int unsigned file_lsb(input int unsigned nr_src);
    return src_width(nr_src);
  endfunction

  function automatic int unsigned hart_lsb(input int unsigned nr_src,
                                           input int unsigned nr_files);
    return src_width(nr_src) + file_width(nr_files);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned high_cyc,
                                            input int unsigned low_cyc);
    return $clog2((high_cyc > low_cyc) ? high_cyc : low_cyc) + 1;
  endfunction

  localparam int unsigned SETIPNUM_LSB = 0;
  localparam int unsigned FILE_LSB     = file_lsb(32);
  localparam int unsigned HART_LSB     = hart_lsb(32, 7);

endpackage

// File: rtl/imsic_msi_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate occupancy counter.
module imsic_msi_fifo
  import imsic_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/imsic_msi_tx.sv
// Bus-side MSI transmitter: filters setipnum requests, buffers them and
// replays each as a timed msi_info_vld pulse with msi_info held stable.
module imsic_msi_tx
  import imsic_pkg::*;
#(
  parameter  int unsigned NR_INTP_FILES   = 7,
  parameter  int unsigned NR_HARTS        = 4,
  parameter  int unsigned NR_SRC          = 32,
  parameter  int unsigned FIFO_DEPTH      = 4,
  parameter  int unsigned VLD_HIGH_CYC    = 4,
  parameter  int unsigned VLD_LOW_CYC     = 8,
  localparam int unsigned NR_HARTS_WIDTH  = hart_width(NR_HARTS),
  localparam int unsigned INTP_FILE_WIDTH = file_width(NR_INTP_FILES),
  localparam int unsigned NR_SRC_WIDTH    = src_width(NR_SRC),
  localparam int unsigned MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_req_vld,
  output logic                       o_req_rdy,
  input  logic [NR_HARTS_WIDTH-1:0]  i_req_hart,
  input  logic [INTP_FILE_WIDTH-1:0] i_req_file,
  input  logic [NR_SRC_WIDTH-1:0]    i_req_setipnum,
  output logic [MSI_INFO_WIDTH-1:0]  o_msi_info,
  output logic                       o_msi_info_vld,
  output logic                       o_busy,
  output logic [7:0]                 o_drop_cnt
);

  localparam int unsigned      CNT_W     = cnt_width(VLD_HIGH_CYC, VLD_LOW_CYC);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(VLD_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(VLD_LOW_CYC - 1);

  msi_state_e                state;
  logic [CNT_W-1:0]          cnt;
  logic                      accept;
  logic                      req_ok;
  logic                      push;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic [MSI_INFO_WIDTH-1:0] fifo_dout;

  // Ready depends only on stored state; a pop while full frees space next cycle.
  assign o_req_rdy = rstn & ~full;
  assign accept    = i_req_vld & o_req_rdy;

  assign req_ok = (i_req_setipnum != '0)
               && (32'(i_req_setipnum) < NR_SRC)
               && (32'(i_req_file) < NR_INTP_FILES)
               && (32'(i_req_hart) < NR_HARTS);

  assign push = accept & req_ok;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_drop_cnt <= '0;
    end else if (accept && !req_ok && o_drop_cnt != '1) begin
      o_drop_cnt <= o_drop_cnt + 8'd1;
    end
  end

  imsic_msi_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MSI_INFO_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   ({i_req_hart, i_req_file, i_req_setipnum}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  assign pop    = ~empty && ((state == IDLE) || (state == LOW && cnt == '0));
  assign o_busy = (state != IDLE) | ~empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= '0;
      o_msi_info     <= '0;
      o_msi_info_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            o_msi_info     <= fifo_dout;
            o_msi_info_vld <= 1'b1;
            cnt            <= HIGH_LOAD;
            state          <= HIGH;
          end
        end
        HIGH: begin
          if (cnt == '0) begin
            o_msi_info_vld <= 1'b0;
            cnt            <= LOW_LOAD;
            state          <= LOW;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (pop) begin
            o_msi_info     <= fifo_dout;
            o_msi_info_vld <= 1'b1;
            cnt            <= HIGH_LOAD;
            state          <= HIGH;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
